// File: rtl/hwag_pkg.sv
// Shared types and defaults for channels hanging off the hardware angle generator.
package hwag_pkg;

  localparam int HWAG_ANGLE_W   = 16;
  localparam int HWAG_ANGLE_MAX = 3839;
  localparam int HWAG_TIME_W    = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SET = 2'd1,
    DWELL    = 2'd2,
    COOLDOWN = 2'd3
  } coil_state_t;

endpackage

// File: rtl/counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable.
module counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/d_flip_flop.sv
// Plain register with asynchronous active-low reset to a configurable value.
module d_flip_flop #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= RST_VAL;
    else
      q <= d;
  end

endmodule

// File: rtl/hwag_cfg_shadow.sv
// Double-buffered configuration: load fills the shadow, apply copies shadow to active.
module hwag_cfg_shadow #(
  parameter int W = 80
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         apply,
  input  logic [W-1:0] d,
  output logic [W-1:0] active
);

  logic [W-1:0] shadow;

  // A load and an apply in the same cycle hand the previous shadow to active.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (load)
        shadow <= d;
      if (apply)
        active <= shadow;
    end
  end

endmodule

// File: rtl/hwag_coil_channel.sv
// One ignition coil channel: angle-defined dwell and spark with max-dwell and min-off guards.
module hwag_coil_channel
  import hwag_pkg::*;
#(
  parameter int ANGLE_W   = HWAG_ANGLE_W,
  parameter int ANGLE_MAX = HWAG_ANGLE_MAX,
  parameter int TIME_W    = HWAG_TIME_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync,
  input  logic [ANGLE_W-1:0] angle,
  input  logic               cfg_wr,
  input  logic [ANGLE_W-1:0] cfg_set_angle,
  input  logic [ANGLE_W-1:0] cfg_spark_angle,
  input  logic [TIME_W-1:0]  cfg_max_dwell,
  input  logic [TIME_W-1:0]  cfg_min_off,
  output logic               coil,
  output logic               spark,
  output logic               dwell_timeout,
  output logic               missed
);

  localparam int                  CFG_W     = 2*ANGLE_W + 2*TIME_W;
  localparam logic [ANGLE_W-1:0]  ANGLE_TOP = ANGLE_W'(ANGLE_MAX);
  localparam logic [TIME_W-1:0]   T_ONE     = {{(TIME_W-1){1'b0}}, 1'b1};

  logic [ANGLE_W-1:0] angle_q;
  logic [ANGLE_W-1:0] angle_prev;
  logic [CFG_W-1:0]   cfg_d;
  logic [CFG_W-1:0]   cfg_active;
  logic [ANGLE_W-1:0] act_set;
  logic [ANGLE_W-1:0] act_spark;
  logic [TIME_W-1:0]  act_max;
  logic [TIME_W-1:0]  act_min;
  logic [TIME_W-1:0]  dwell_cnt;
  logic [TIME_W-1:0]  off_cnt;
  logic               wrap;
  logic               angle_new;
  logic               set_match;
  logic               spark_match;
  coil_state_t        state;
  coil_state_t        state_n;
  logic               coil_n;
  logic               spark_n;
  logic               timeout_n;
  logic               missed_n;

  // Stage p0: angle capture and one-cycle history for edge qualification
  d_flip_flop #(.W(ANGLE_W), .RST_VAL(ANGLE_TOP)) u_angle_q (
    .clk (clk),
    .rst (rst),
    .d   (angle),
    .q   (angle_q)
  );

  d_flip_flop #(.W(ANGLE_W), .RST_VAL(ANGLE_TOP)) u_angle_prev (
    .clk (clk),
    .rst (rst),
    .d   (angle_q),
    .q   (angle_prev)
  );

  assign wrap      = (angle_q == '0) && (angle == ANGLE_TOP);
  assign angle_new = (angle_q != angle_prev);

  // Config is frozen while synchronised and only swapped at the revolution boundary.
  assign cfg_d = {cfg_set_angle, cfg_spark_angle, cfg_max_dwell, cfg_min_off};

  hwag_cfg_shadow #(.W(CFG_W)) u_cfg (
    .clk    (clk),
    .rst    (rst),
    .load   (cfg_wr),
    .apply  (wrap || !sync),
    .d      (cfg_d),
    .active (cfg_active)
  );

  assign act_set   = cfg_active[CFG_W-1 -: ANGLE_W];
  assign act_spark = cfg_active[CFG_W-ANGLE_W-1 -: ANGLE_W];
  assign act_max   = cfg_active[2*TIME_W-1 -: TIME_W];
  assign act_min   = cfg_active[TIME_W-1:0];

  // Out-of-range targets can never equal a legal angle, so they simply never fire.
  assign set_match   = angle_new && (angle_q == act_set)   && (act_set   <= ANGLE_TOP);
  assign spark_match = angle_new && (angle_q == act_spark) && (act_spark <= ANGLE_TOP);

  // Stage p1: dwell/off timers, held at zero outside their own state
  counter #(.W(TIME_W)) u_dwell_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != DWELL),
    .en  (state == DWELL),
    .cnt (dwell_cnt)
  );

  counter #(.W(TIME_W)) u_off_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != COOLDOWN),
    .en  (state == COOLDOWN),
    .cnt (off_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    spark_n   = 1'b0;
    timeout_n = 1'b0;
    missed_n  = 1'b0;
    if (!sync) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:     state_n = WAIT_SET;
        WAIT_SET: if (set_match) state_n = DWELL;
        DWELL: begin
          if (spark_match) begin
            state_n = COOLDOWN;
            spark_n = 1'b1;
          end else if ((act_max != '0) && ((dwell_cnt + T_ONE) == act_max)) begin
            state_n   = COOLDOWN;
            timeout_n = 1'b1;
          end
        end
        COOLDOWN: begin
          if (set_match)
            missed_n = 1'b1;
          else if (off_cnt >= act_min)
            state_n = WAIT_SET;
        end
        default:  state_n = IDLE;
      endcase
    end
    coil_n = (state_n == DWELL);
  end

  // Stage p2: registered outputs, pulses aligned with the coil edge
  d_flip_flop #(.W(4), .RST_VAL(4'b0000)) u_out (
    .clk (clk),
    .rst (rst),
    .d   ({coil_n, spark_n, timeout_n, missed_n}),
    .q   ({coil, spark, dwell_timeout, missed})
  );

endmodule

// File: tb/tb_hwag_coil_channel.sv
// Scoreboard bench for hwag_coil_channel: angle sweeps, config changes, sync drops and reset.
module tb_hwag_coil_channel;

  typedef struct packed {
    logic coil;
    logic spark;
    logic tmo;
    logic missed;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sync = 1'b0;
  logic [15:0] angle = 16'd3839;
  logic        cfg_wr = 1'b0;
  logic [15:0] cfg_set_angle = '0;
  logic [15:0] cfg_spark_angle = '0;
  logic [23:0] cfg_max_dwell = '0;
  logic [23:0] cfg_min_off = '0;
  logic        coil, spark, dwell_timeout, missed;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cur = 3839;
  int   dut_coil_cyc = 0, dut_spark = 0, dut_tmo = 0, dut_missed = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: channel phase flags plus edge timestamps
  int     m_aq, m_aqq;
  int     sh_set, sh_spk, sh_max, sh_min;
  int     ac_set, ac_spk, ac_max, ac_min;
  bit     m_run, m_on, m_cool;
  longint m_t = 0, m_t_on = 0, m_t_cool = 0;

  hwag_coil_channel dut (
    .clk             (clk),
    .rst             (rst),
    .sync            (sync),
    .angle           (angle),
    .cfg_wr          (cfg_wr),
    .cfg_set_angle   (cfg_set_angle),
    .cfg_spark_angle (cfg_spark_angle),
    .cfg_max_dwell   (cfg_max_dwell),
    .cfg_min_off     (cfg_min_off),
    .coil            (coil),
    .spark           (spark),
    .dwell_timeout   (dwell_timeout),
    .missed          (missed)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_aq = 3839; m_aqq = 3839;
    sh_set = 0; sh_spk = 0; sh_max = 0; sh_min = 0;
    ac_set = 0; ac_spk = 0; ac_max = 0; ac_min = 0;
    m_run = 0; m_on = 0; m_cool = 0;
  endtask

  task automatic model_edge(output exp_t e);
    bit fresh, hs, hp, wrap;
    fresh = (m_aq != m_aqq);
    hs    = fresh && (m_aq == ac_set);
    hp    = fresh && (m_aq == ac_spk);
    wrap  = (m_aq == 0) && (int'(angle) == 3839);
    e = '0;
    if (!sync) begin
      m_run = 0; m_on = 0; m_cool = 0;
    end else if (!m_run) begin
      m_run = 1;
    end else if (m_on) begin
      if (hp) begin
        e.spark = 1; m_on = 0; m_cool = 1; m_t_cool = m_t;
      end else if (ac_max != 0 && (m_t - m_t_on) == longint'(ac_max)) begin
        e.tmo = 1; m_on = 0; m_cool = 1; m_t_cool = m_t;
      end
    end else if (m_cool) begin
      if (hs) e.missed = 1;
      else if ((m_t - m_t_cool) > longint'(ac_min)) m_cool = 0;
    end else if (hs) begin
      m_on = 1; m_t_on = m_t;
    end
    e.coil = m_on;
    if (wrap || !sync) begin
      ac_set = sh_set; ac_spk = sh_spk; ac_max = sh_max; ac_min = sh_min;
    end
    if (cfg_wr) begin
      sh_set = int'(cfg_set_angle); sh_spk = int'(cfg_spark_angle);
      sh_max = int'(cfg_max_dwell); sh_min = int'(cfg_min_off);
    end
    m_aqq = m_aq;
    m_aq  = int'(angle);
    m_t++;
  endtask

  task automatic cycle();
    exp_t e;
    angle = 16'(cur);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      model_edge(e);
      exp_q.push_back(e);
    end
    #1;
    cfg_wr = 1'b0;
  endtask

  task automatic step(input int hmin, input int hmax);
    int h;
    cur = (cur == 0) ? 3839 : cur - 1;
    h = $urandom_range(hmax, hmin);
    repeat (h) cycle();
  endtask

  task automatic run_steps(input int n, input int hmin, input int hmax);
    repeat (n) step(hmin, hmax);
  endtask

  task automatic run_to(input int target, input int hmin, input int hmax);
    while (cur != target) step(hmin, hmax);
  endtask

  task automatic set_cfg(input int s, input int p, input int mx, input int mn);
    cfg_set_angle   = 16'(s);
    cfg_spark_angle = 16'(p);
    cfg_max_dwell   = 24'(mx);
    cfg_min_off     = 24'(mn);
    cfg_wr          = 1'b1;
    cycle();
  endtask

  task automatic apply_now();
    sync = 1'b0;
    cycle();
    sync = 1'b1;
  endtask

  task automatic zero_counts();
    dut_coil_cyc = 0; dut_spark = 0; dut_tmo = 0; dut_missed = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (coil) dut_coil_cyc++;
      if (spark) dut_spark++;
      if (dwell_timeout) dut_tmo++;
      if (missed) dut_missed++;
    end
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("coil", coil, mon_e.coil);
      chk("spark", spark, mon_e.spark);
      chk("dwell_timeout", dwell_timeout, mon_e.tmo);
      chk("missed", missed, mon_e.missed);
    end
  end

  initial begin
    model_reset();
    repeat (2) cycle();
    chk("reset_coil", coil, 1'b0);
    chk("reset_spark", spark, 1'b0);
    chk("reset_timeout", dwell_timeout, 1'b0);
    chk("reset_missed", missed, 1'b0);
    rst = 1'b1;

    // Basic sweep at 4 clk per tick: one dwell of exactly 400 clk
    set_cfg(1000, 900, 0, 10);
    apply_now();
    zero_counts();
    run_steps(3840, 4, 4);
    chk_int("s1_coil_cycles", dut_coil_cyc, 400);
    chk_int("s1_sparks", dut_spark, 1);
    chk_int("s1_timeouts", dut_tmo, 0);

    // Max-dwell guard over two revolutions
    set_cfg(1000, 900, 50, 10);
    apply_now();
    zero_counts();
    run_steps(7680, 1, 2);
    chk_int("s2_coil_cycles", dut_coil_cyc, 100);
    chk_int("s2_timeouts", dut_tmo, 2);
    chk_int("s2_sparks", dut_spark, 0);

    // Long min-off: the next revolution's set angle lands in cooldown
    set_cfg(1000, 990, 0, 3900 + $urandom_range(99, 0));
    apply_now();
    zero_counts();
    run_steps(7680, 1, 1);
    chk_int("s3_missed", dut_missed, 1);
    chk_int("s3_sparks", dut_spark, 1);
    chk_int("s3_coil_cycles", dut_coil_cyc, 10);

    // Mid-revolution config write takes effect only after wrap
    set_cfg(1000, 900, 0, 10);
    apply_now();
    zero_counts();
    run_to(2000, 1, 1);
    set_cfg(500, 450, 0, 10);
    run_to(3839, 1, 1);
    run_steps(3840, 1, 1);
    chk_int("s4_sparks", dut_spark, 2);
    chk_int("s4_coil_cycles", dut_coil_cyc, 150);

    // Sync drop during dwell aborts without a spark
    set_cfg(1000, 900, 0, 10);
    apply_now();
    zero_counts();
    run_to(950, 1, 1);
    sync = 1'b0;
    cycle();
    cycle();
    chk("s5_coil_after_sync_drop", coil, 1'b0);
    cycle();
    sync = 1'b1;
    run_to(3839, 1, 1);
    run_steps(3840, 1, 1);
    chk_int("s5_sparks", dut_spark, 1);
    chk_int("s5_timeouts", dut_tmo, 0);

    // Asynchronous reset in the middle of a dwell
    run_to(950, 1, 1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("s6_rst_coil", coil, 1'b0);
    chk("s6_rst_spark", spark, 1'b0);
    chk("s6_rst_timeout", dwell_timeout, 1'b0);
    chk("s6_rst_missed", missed, 1'b0);
    cycle();
    cycle();
    rst = 1'b1;
    zero_counts();
    run_steps(1000, 1, 2);
    chk_int("s6_zero_cfg_dwells", int'(dut_coil_cyc > 0), 1);
    chk_int("s6_zero_cfg_sparks", dut_spark, 0);

    // Randomised configs, some written exactly at wrap, with occasional sync glitches
    for (int it = 0; it < 4; it++) begin
      int s, p, mx, mn;
      s  = $urandom_range(4000, 0);
      p  = ($urandom_range(3, 0) == 0) ? s : $urandom_range(4000, 0);
      mx = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(300, 1);
      mn = $urandom_range(500, 0);
      if (it % 2 == 1) begin
        run_to(0, 1, 1);
        cfg_set_angle   = 16'(s);
        cfg_spark_angle = 16'(p);
        cfg_max_dwell   = 24'(mx);
        cfg_min_off     = 24'(mn);
        cfg_wr          = 1'b1;
        step(1, 1);
      end else begin
        set_cfg(s, p, mx, mn);
      end
      repeat (1920) begin
        if ($urandom_range(299, 0) == 0) begin
          sync = 1'b0;
          repeat ($urandom_range(3, 1)) cycle();
          sync = 1'b1;
        end
        step(1, 2);
      end
    end

    repeat (3) cycle();
    @(negedge clk);
    #1;
    chk_int("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
